// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin fifo write arbiter.
package fifo_arb_pkg;

    localparam int DATA_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Width of an index into n requesters; never zero so ports stay legal.
    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = owner_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic               valid,
    output logic [IW-1:0]      index
);

    int idx;

    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    always_comb begin
        valid = |req;
        index = '0;
        idx   = 0;
        // Walk from the farthest candidate back so the nearest one wins last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req[idx]) begin
                index = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting bursts of fifo writes to one requester at a time.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4,
    parameter int MAX_DATA  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [DATA_W*NUM_REQ-1:0]    req_data,
    output logic [NUM_REQ-1:0]           gnt,
    input  logic                         fifo_full,
    input  logic [4:0]                   fifo_count,
    output logic                         fifo_wen,
    output logic [DATA_W-1:0]            fifo_wdata,
    output logic [owner_w(NUM_REQ)-1:0]  owner,
    output logic                         busy
);

    localparam int IW = owner_w(NUM_REQ);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    arb_state_t    state, state_d;
    logic [IW-1:0] rr_ptr, rr_ptr_d;
    logic [IW-1:0] owner_d, owner_next;
    logic [BW-1:0] beat_cnt, beat_cnt_d;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic          room;
    logic          owner_req;
    logic          beat;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .valid   (pick_valid),
        .index   (pick_idx)
    );

    assign room       = !fifo_full && (int'(fifo_count) < MAX_DATA);
    assign owner_req  = req[owner];
    assign beat       = (state == BURST) && owner_req && room;
    assign owner_next = (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_d;
            rr_ptr   <= rr_ptr_d;
            owner    <= owner_d;
            beat_cnt <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state;
        rr_ptr_d   = rr_ptr;
        owner_d    = owner;
        beat_cnt_d = beat_cnt;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_d    = BURST;
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                // A dropped request ends the tenure without a beat; stalls keep it open.
                if (!owner_req || (beat && beat_cnt == LAST_BEAT)) begin
                    state_d  = IDLE;
                    rr_ptr_d = owner_next;
                end else if (beat) begin
                    beat_cnt_d = beat_cnt + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        gnt        = '0;
        busy       = (state == BURST);
        fifo_wen   = 1'b0;
        fifo_wdata = '0;
        if (state == BURST) begin
            gnt[owner] = room;
            fifo_wen   = owner_req && room;
            fifo_wdata = req_data[int'(owner)*DATA_W +: DATA_W];
        end
    end

`ifdef FORMAL
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_no_wen_full: assert property (@(posedge clk) disable iff (!rst_n) !(fifo_wen && fifo_full));
    a_gnt_in_burst: assert property (@(posedge clk) disable iff (!rst_n) (gnt != '0) |-> (state == BURST));
    a_beat_range: assert property (@(posedge clk) disable iff (!rst_n) int'(beat_cnt) < MAX_BURST);
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised scoreboard bench for fifo_wr_arbiter with a behavioural tenure model.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int N  = 4;
    localparam int MB = 4;
    localparam int MD = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_data = '0;
    logic           fifo_full = 1'b0;
    logic [4:0]     fifo_count = '0;
    logic [N-1:0]   gnt;
    logic           fifo_wen;
    logic [7:0]     fifo_wdata;
    logic [1:0]     owner;
    logic           busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .MAX_BURST  (MB),
        .MAX_DATA   (MD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .fifo_wen   (fifo_wen),
        .fifo_wdata (fifo_wdata),
        .owner      (owner),
        .busy       (busy)
    );

    typedef struct packed {
        logic [N-1:0] gnt;
        logic         wen;
        logic [7:0]   wdata;
        logic [1:0]   owner;
        logic         busy;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    int   count   = 0;
    int   max_count = 0;
    logic last_wen = 1'b0;

    // Reference model: who holds the tenure, how many beats it has delivered, where the scan starts.
    bit m_ten   = 1'b0;
    int m_cur   = 0;
    int m_ptr   = 0;
    int m_beats = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    task automatic model_step(input logic rst, input logic [N-1:0] r, input logic [8*N-1:0] d,
                              input logic full, input int cnt, output exp_t e);
        bit room;
        bit found;
        e = '0;
        e.owner = 2'(m_cur);
        if (!rst) begin
            m_ten = 1'b0; m_cur = 0; m_ptr = 0; m_beats = 0;
            e.owner = '0;
        end else if (!m_ten) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && r[(m_ptr + k) % N]) begin
                    found = 1'b1;
                    m_cur = (m_ptr + k) % N;
                end
            end
            if (found) begin
                m_ten = 1'b1;
                m_beats = 0;
            end
        end else begin
            room = !full && (cnt < MD);
            e.busy = 1'b1;
            if (room) e.gnt[m_cur] = 1'b1;
            e.wen = r[m_cur] && room;
            e.wdata = d[8*m_cur +: 8];
            if (e.wen) m_beats++;
            if (!r[m_cur] || m_beats == MB) begin
                m_ten = 1'b0;
                m_ptr = (m_cur + 1) % N;
            end
        end
    endtask

    task automatic step(input logic rst, input logic [N-1:0] r, input int drain_pct);
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (!rst) begin
            count = 0;
        end else begin
            count += int'(last_wen);
            if (count > max_count) max_count = count;
            if (count > 0 && int'($urandom_range(99)) < drain_pct) count--;
        end
        rst_n      = rst;
        req        = r;
        req_data   = $urandom;
        fifo_count = 5'(count);
        fifo_full  = (count >= MD);
        #1;
        model_step(rst, r, req_data, fifo_full, count, e);
        sb_q.push_back(e);
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle against DUT outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            last_wen = fifo_wen;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("gnt", 32'(gnt), 32'(e.gnt));
                check("fifo_wen", 32'(fifo_wen), 32'(e.wen));
                check("owner", 32'(owner), 32'(e.owner));
                check("busy", 32'(busy), 32'(e.busy));
                if (e.wen) check("fifo_wdata", 32'(fifo_wdata), 32'(e.wdata));
                check("wen_while_full", 32'(fifo_wen && fifo_full), 32'd0);
            end
        end
    end

    initial begin
        repeat (3) step(1'b0, '0, 0);
        // Lone requester, no draining: two back-to-back tenures with a bubble.
        repeat (12) step(1'b1, 4'b0001, 0);
        repeat (10) step(1'b1, 4'b0000, 100);
        // All requesting from a fresh reset: tenures 0,1,2,3,0.
        step(1'b0, '0, 100);
        repeat (26) step(1'b1, 4'b1111, 100);
        repeat (20) step(1'b1, 4'b0101, 100);
        repeat (4) step(1'b1, 4'b0000, 100);
        // Near-full fifo: one beat, stall on full, resume as it drains.
        count = 15;
        repeat (6) step(1'b1, 4'b0010, 0);
        repeat (10) step(1'b1, 4'b0010, 100);
        // Owner drops its request mid-tenure.
        repeat (4) step(1'b1, 4'b0100, 100);
        repeat (3) step(1'b1, 4'b0000, 100);
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(199) != 0), N'($urandom), int'($urandom_range(100)));
        end
        // Reset in the middle of a burst, then a fresh tenure for requester 3.
        step(1'b0, '0, 100);
        repeat (4) step(1'b1, 4'b1000, 100);
        repeat (2) step(1'b0, 4'b1000, 100);
        repeat (8) step(1'b1, 4'b1000, 100);
        @(negedge clk);
        #1;
        check("queue_drained", 32'(sb_q.size()), 32'd0);
        check("count_bound", 32'(max_count <= MD), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
